// File: rtl/mastermind_pkg.sv
// Shared state encoding, default game dimensions and width helpers for the
// Mastermind engine and its scoring datapath.
package mastermind_pkg;

    localparam int DEF_NUM_PEGS  = 4;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_MAX_TURNS = 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_GUESS = 3'd1,
        S_SCAN       = 3'd2,
        S_TALLY      = 3'd3,
        S_REPORT     = 3'd4,
        S_WON        = 3'd5,
        S_LOST       = 3'd6
    } state_t;

    // Bits needed to hold any count 0..max_val.
    function automatic int count_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index 0..n-1 (never narrower than one bit).
    function automatic int index_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mastermind_score_seq.sv
// SCAN/TALLY scoring datapath: per-peg exact-match counter and colour
// histograms, then a per-colour min() accumulator. Sequenced by the engine.
module mastermind_score_seq
    import mastermind_pkg::*;
#(
    parameter int NUM_PEGS = DEF_NUM_PEGS,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int CNT_W    = count_w(NUM_PEGS),
    parameter int STEP_W   = index_w(max2(NUM_PEGS, 1 << COLOR_W))
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         scan_en,
    input  logic                         tally_en,
    input  logic [STEP_W-1:0]            step,
    input  logic [NUM_PEGS*COLOR_W-1:0]  secret,
    input  logic [NUM_PEGS*COLOR_W-1:0]  guess,
    output logic [CNT_W-1:0]             black,
    output logic [CNT_W-1:0]             acc,
    output logic                         done
);

    localparam int NUM_COLORS = 1 << COLOR_W;

    logic [CNT_W-1:0]   sec_cnt [NUM_COLORS];
    logic [CNT_W-1:0]   gss_cnt [NUM_COLORS];
    logic [COLOR_W-1:0] sec_peg;
    logic [COLOR_W-1:0] gss_peg;
    logic [COLOR_W-1:0] color;
    logic [CNT_W-1:0]   min_cnt;

    always_comb begin
        sec_peg = '0;
        gss_peg = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (step == STEP_W'(i)) begin
                sec_peg = secret[i*COLOR_W +: COLOR_W];
                gss_peg = guess[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign color   = step[COLOR_W-1:0];
    assign min_cnt = (sec_cnt[color] < gss_cnt[color]) ? sec_cnt[color] : gss_cnt[color];
    assign done    = tally_en && (step == STEP_W'(NUM_COLORS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            black <= '0;
            acc   <= '0;
            for (int c = 0; c < NUM_COLORS; c++) begin
                sec_cnt[c] <= '0;
                gss_cnt[c] <= '0;
            end
        end else if (clear) begin
            black <= '0;
            acc   <= '0;
            for (int c = 0; c < NUM_COLORS; c++) begin
                sec_cnt[c] <= '0;
                gss_cnt[c] <= '0;
            end
        end else begin
            if (scan_en) begin
                if (sec_peg == gss_peg) begin
                    black <= black + CNT_W'(1);
                end
                sec_cnt[sec_peg] <= sec_cnt[sec_peg] + CNT_W'(1);
                gss_cnt[gss_peg] <= gss_cnt[gss_peg] + CNT_W'(1);
            end
            if (tally_en) begin
                acc <= acc + min_cnt;
            end
        end
    end

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind game engine: secret latch, guess handshake, turn/win/lose tracking
// and per-turn history (history storage only when MASTERMIND_HISTORY_EN is defined).
module mastermind_engine
    import mastermind_pkg::*;
#(
    parameter int NUM_PEGS  = DEF_NUM_PEGS,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int MAX_TURNS = DEF_MAX_TURNS,
    localparam int CNT_W    = count_w(NUM_PEGS),
    localparam int TURN_W   = count_w(MAX_TURNS),
    localparam int CODE_W   = NUM_PEGS * COLOR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CODE_W-1:0] secret,
    input  logic              guess_valid,
    input  logic [CODE_W-1:0] guess,
    output logic              guess_ready,
    output logic              result_valid,
    output logic [CNT_W-1:0]  black,
    output logic [CNT_W-1:0]  white,
    output logic [TURN_W-1:0] turn,
    output logic              busy,
    output logic              won,
    output logic              lost,
    input  logic [TURN_W-1:0] hist_idx,
    output logic [CODE_W-1:0] hist_guess,
    output logic [CNT_W-1:0]  hist_black,
    output logic [CNT_W-1:0]  hist_white,
    output state_t            dbg_state
);

    localparam int NUM_COLORS = 1 << COLOR_W;
    localparam int STEP_W     = index_w(max2(NUM_PEGS, NUM_COLORS));

    state_t            state;
    logic [CODE_W-1:0] secret_q;
    logic [CODE_W-1:0] guess_q;
    logic [STEP_W-1:0] step;
    logic [CNT_W-1:0]  sc_black;
    logic [CNT_W-1:0]  sc_acc;
    logic              sc_done;
    logic              accept;

    // Handshake: a guess transfers on a rising edge where guess_valid && guess_ready;
    // guess_ready is high only in WAIT_GUESS and the source holds guess stable until
    // transfer. A start in the same cycle takes priority and the guess is dropped.
    assign accept    = guess_valid && guess_ready && !start;
    assign dbg_state = state;

    mastermind_score_seq #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W),
        .STEP_W   (STEP_W)
    ) u_score (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start || accept),
        .scan_en  (state == S_SCAN),
        .tally_en (state == S_TALLY),
        .step     (step),
        .secret   (secret_q),
        .guess    (guess_q),
        .black    (sc_black),
        .acc      (sc_acc),
        .done     (sc_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            secret_q     <= '0;
            guess_q      <= '0;
            step         <= '0;
            guess_ready  <= 1'b0;
            result_valid <= 1'b0;
            black        <= '0;
            white        <= '0;
            turn         <= '0;
            busy         <= 1'b0;
            won          <= 1'b0;
            lost         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (start) begin
                // Abort whatever is in flight; the new game starts clean.
                state       <= S_WAIT_GUESS;
                secret_q    <= secret;
                step        <= '0;
                guess_ready <= 1'b1;
                black       <= '0;
                white       <= '0;
                turn        <= '0;
                busy        <= 1'b0;
                won         <= 1'b0;
                lost        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_WAIT_GUESS: begin
                        if (accept) begin
                            guess_q     <= guess;
                            step        <= '0;
                            guess_ready <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (step == STEP_W'(NUM_PEGS - 1)) begin
                            step  <= '0;
                            state <= S_TALLY;
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end
                    S_TALLY: begin
                        if (sc_done) begin
                            state <= S_REPORT;
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end
                    S_REPORT: begin
                        result_valid <= 1'b1;
                        black        <= sc_black;
                        white        <= sc_acc - sc_black;
                        turn         <= turn + TURN_W'(1);
                        busy         <= 1'b0;
                        // A full exact match wins even on the last allowed turn.
                        if (sc_black == CNT_W'(NUM_PEGS)) begin
                            won   <= 1'b1;
                            state <= S_WON;
                        end else if (turn == TURN_W'(MAX_TURNS - 1)) begin
                            lost  <= 1'b1;
                            state <= S_LOST;
                        end else begin
                            guess_ready <= 1'b1;
                            state       <= S_WAIT_GUESS;
                        end
                    end
                    S_WON, S_LOST: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef MASTERMIND_HISTORY_EN
    logic [CODE_W-1:0] hist_g_mem [MAX_TURNS];
    logic [CNT_W-1:0]  hist_b_mem [MAX_TURNS];
    logic [CNT_W-1:0]  hist_w_mem [MAX_TURNS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_TURNS; i++) begin
                hist_g_mem[i] <= '0;
                hist_b_mem[i] <= '0;
                hist_w_mem[i] <= '0;
            end
        end else if (state == S_REPORT && !start) begin
            for (int i = 0; i < MAX_TURNS; i++) begin
                if (turn == TURN_W'(i)) begin
                    hist_g_mem[i] <= guess_q;
                    hist_b_mem[i] <= sc_black;
                    hist_w_mem[i] <= sc_acc - sc_black;
                end
            end
        end
    end

    // Entries at or beyond the current turn are stale from an earlier game.
    always_comb begin
        hist_guess = '0;
        hist_black = '0;
        hist_white = '0;
        for (int i = 0; i < MAX_TURNS; i++) begin
            if (hist_idx == TURN_W'(i) && hist_idx < turn) begin
                hist_guess = hist_g_mem[i];
                hist_black = hist_b_mem[i];
                hist_white = hist_w_mem[i];
            end
        end
    end
`else
    logic hist_idx_unused;

    assign hist_idx_unused = ^hist_idx;
    assign hist_guess      = '0;
    assign hist_black      = '0;
    assign hist_white      = '0;
`endif

endmodule

// File: tb/tb_mastermind_engine.sv
// Self-checking bench for mastermind_engine: scoreboard of expected scores,
// game flow, abort/reset cases and history readback (history build-dependent).
module tb_mastermind_engine;
    import mastermind_pkg::*;

    localparam int NUM_PEGS  = 4;
    localparam int COLOR_W   = 3;
    localparam int MAX_TURNS = 8;
    localparam int CNT_W     = 3;
    localparam int TURN_W    = 4;
    localparam int CODE_W    = 12;
    localparam int LAT       = NUM_PEGS + (1 << COLOR_W) + 1;
    localparam int EW        = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CODE_W-1:0] secret = '0;
    logic              guess_valid = 1'b0;
    logic [CODE_W-1:0] guess = '0;
    logic              guess_ready;
    logic              result_valid;
    logic [CNT_W-1:0]  black;
    logic [CNT_W-1:0]  white;
    logic [TURN_W-1:0] turn;
    logic              busy;
    logic              won;
    logic              lost;
    logic [TURN_W-1:0] hist_idx = '0;
    logic [CODE_W-1:0] hist_guess;
    logic [CNT_W-1:0]  hist_black;
    logic [CNT_W-1:0]  hist_white;
    state_t            dbg_state;

    mastermind_engine #(
        .NUM_PEGS  (NUM_PEGS),
        .COLOR_W   (COLOR_W),
        .MAX_TURNS (MAX_TURNS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .secret       (secret),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ready  (guess_ready),
        .result_valid (result_valid),
        .black        (black),
        .white        (white),
        .turn         (turn),
        .busy         (busy),
        .won          (won),
        .lost         (lost),
        .hist_idx     (hist_idx),
        .hist_guess   (hist_guess),
        .hist_black   (hist_black),
        .hist_white   (hist_white),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     mon_e;
    int unsigned       acc_cyc = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    logic [CODE_W-1:0] m_secret = '0;
    int                m_turn = 0;
    bit                m_over = 1'b0;
    logic [CODE_W-1:0] hm_guess [MAX_TURNS];
    int                hm_b [MAX_TURNS];
    int                hm_w [MAX_TURNS];
    logic [CODE_W-1:0] rs;
    logic [CODE_W-1:0] rg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CODE_W-1:0] mk(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    // Reference scoring: mark exact matches, then pair each remaining secret
    // peg with the first unused remaining guess peg of the same colour.
    function automatic void score_model(input logic [CODE_W-1:0] s, input logic [CODE_W-1:0] g,
                                        output int b, output int w);
        bit us [NUM_PEGS];
        bit ug [NUM_PEGS];
        bit found;
        b = 0;
        w = 0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            us[i] = 1'b0;
            ug[i] = 1'b0;
        end
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (s[i*COLOR_W +: COLOR_W] == g[i*COLOR_W +: COLOR_W]) begin
                b++;
                us[i] = 1'b1;
                ug[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (!us[i]) begin
                found = 1'b0;
                for (int j = 0; j < NUM_PEGS; j++) begin
                    if (!found && !ug[j] && s[i*COLOR_W +: COLOR_W] == g[j*COLOR_W +: COLOR_W]) begin
                        found = 1'b1;
                        ug[j] = 1'b1;
                        w++;
                    end
                end
            end
        end
    endfunction

    function automatic logic [CODE_W-1:0] nonwin(input logic [CODE_W-1:0] s);
        logic [CODE_W-1:0] g;
        g = CODE_W'($urandom_range(0, (1 << CODE_W) - 1));
        if (g == s) g = g ^ CODE_W'(1);
        return g;
    endfunction

    // Monitor: every result pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("score", {3'b0, black, white, turn, won, lost, guess_ready}, mon_e);
                check("latency", cyc - acc_cyc, LAT);
            end
        end
    end

    // Driver tasks
    task automatic do_start(input logic [CODE_W-1:0] s);
        @(negedge clk);
        start    = 1'b1;
        secret   = s;
        m_secret = s;
        m_turn   = 0;
        m_over   = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_guess(input logic [CODE_W-1:0] g, input bit scored);
        int n;
        int b;
        int w;
        bit won_e;
        bit lost_e;
        n = 0;
        @(negedge clk);
        while (!guess_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!guess_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        guess_valid = 1'b1;
        guess       = g;
        if (scored) begin
            score_model(m_secret, g, b, w);
            hm_guess[m_turn] = g;
            hm_b[m_turn]     = b;
            hm_w[m_turn]     = w;
            m_turn++;
            won_e  = (b == NUM_PEGS);
            lost_e = !won_e && (m_turn == MAX_TURNS);
            m_over = won_e || lost_e;
            exp_q.push_back({3'b0, 3'(b), 3'(w), 4'(m_turn), won_e, lost_e, !(won_e || lost_e)});
        end
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic check_hist(input int idx);
        logic [CODE_W-1:0] eg;
        logic [CNT_W-1:0]  eb;
        logic [CNT_W-1:0]  ew;
        hist_idx = TURN_W'(idx);
        eg = '0;
        eb = '0;
        ew = '0;
`ifdef MASTERMIND_HISTORY_EN
        if (idx < m_turn) begin
            eg = hm_guess[idx];
            eb = CNT_W'(hm_b[idx]);
            ew = CNT_W'(hm_w[idx]);
        end
`endif
        #1;
        check("hist_guess", hist_guess, eg);
        check("hist_black", hist_black, eb);
        check("hist_white", hist_white, ew);
        hist_idx = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_flags"}, {guess_ready, result_valid, busy, won, lost}, 0);
        check({tag, "_score"}, {black, white, turn}, 0);
        check({tag, "_hist"}, {hist_guess, hist_black, hist_white}, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", guess_ready, 0);

        // Exact match on the first guess wins
        do_start(12'h0E4);
        check("start_ready", guess_ready, 1);
        send_guess(12'h0E4, 1'b1);
        wait_done();
        check("won_hold", {won, lost, guess_ready, busy}, 4'b1000);

        // All colours present, none in place
        do_start(mk(1, 2, 3, 4));
        send_guess(mk(4, 3, 2, 1), 1'b1);
        wait_done();
        check("wait_state", dbg_state, S_WAIT_GUESS);

        // Duplicate colours; history readback of turn 0
        do_start(mk(1, 1, 2, 2));
        send_guess(mk(1, 2, 1, 3), 1'b1);
        wait_done();
        check_hist(0);
        check_hist(1);

        // Eight misses lose
        do_start(mk(1, 2, 3, 4));
        for (int t = 0; t < MAX_TURNS; t++) begin
            send_guess(nonwin(m_secret), 1'b1);
            wait_done();
        end
        check("lost_hold", {won, lost, guess_ready}, 3'b010);
        check_hist(MAX_TURNS - 1);
        check_hist(MAX_TURNS);

        // Exact match on the final turn wins, not loses
        do_start(mk(7, 0, 7, 5));
        for (int t = 0; t < MAX_TURNS - 1; t++) begin
            send_guess(nonwin(m_secret), 1'b1);
            wait_done();
        end
        send_guess(m_secret, 1'b1);
        wait_done();
        check("final_win", {won, lost, turn}, {2'b10, 4'(MAX_TURNS)});

        // start during TALLY aborts the guess in flight
        do_start(mk(5, 6, 7, 0));
        send_guess(mk(5, 6, 0, 7), 1'b0);
        repeat (6) @(negedge clk);
        check("in_tally", dbg_state, S_TALLY);
        start    = 1'b1;
        secret   = mk(2, 2, 5, 5);
        m_secret = secret;
        m_turn   = 0;
        @(negedge clk);
        start = 1'b0;
        check("abort_state", {guess_ready, busy, turn}, {2'b10, 4'd0});
        repeat (16) @(negedge clk);
        check("abort_no_result", turn, 0);

        // start and guess_valid together: guess dropped
        start       = 1'b1;
        guess_valid = 1'b1;
        guess       = mk(2, 2, 5, 5);
        @(negedge clk);
        start       = 1'b0;
        guess_valid = 1'b0;
        check("start_wins", {guess_ready, busy, dbg_state}, {2'b10, S_WAIT_GUESS});
        send_guess(mk(2, 5, 5, 2), 1'b1);
        wait_done();

        // Asynchronous reset in the middle of SCAN
        send_guess(mk(2, 2, 1, 1), 1'b0);
        check("busy_scan", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("rst_mid_scan");
        exp_q.delete();
        m_turn = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random games
        for (int gm = 0; gm < 4; gm++) begin
            rs = CODE_W'($urandom_range(0, (1 << CODE_W) - 1));
            do_start(rs);
            while (!m_over && m_turn < MAX_TURNS) begin
                if ($urandom_range(0, 5) == 0) rg = rs;
                else rg = CODE_W'($urandom_range(0, (1 << CODE_W) - 1));
                send_guess(rg, 1'b1);
                wait_done();
            end
            check_hist($urandom_range(0, m_turn - 1));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
